// File: rtl/pc_control_pkg.sv
// Shared types and constants for the fetch-side program counter controller.
package pc_control_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HALTED
  } pc_state_t;

  localparam int DEFAULT_PC_W         = 16;
  localparam int DEFAULT_FLUSH_CYCLES = 2;
  localparam int TAKEN_W              = 16;
  // Wide enough for the largest legal flush depth of 7.
  localparam int FLUSH_CNT_W          = 3;

endpackage

// File: rtl/pc_control_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping back to zero.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (inc && (value != {WIDTH{1'b1}})) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_control.sv
// Program counter sequencing: linear fetch, taken branches with a squash
// window for wrong-path slots, and a sticky halt that only reset clears.
module pc_control
  import pc_control_pkg::*;
#(
  parameter int              PC_W         = DEFAULT_PC_W,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_pc,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               stall,
  input  logic               halt_req,
  output logic [PC_W-1:0]    pc,
  output logic               flush,
  output logic               halted,
  output logic [TAKEN_W-1:0] taken_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES);

  pc_state_t              state_q, state_d;
  logic [PC_W-1:0]        pc_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   taken_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc          <= RESET_PC;
      flush_cnt_q <= '0;
      flush       <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      flush_cnt_q <= flush_cnt_d;
      flush       <= (state_d == ST_FLUSH);
      halted      <= (state_d == ST_HALTED);
    end
  end

  // In FLUSH the branch and halt inputs come from squashed instructions,
  // so only stall is honoured there.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc;
    flush_cnt_d = flush_cnt_q;
    taken_inc   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (sel_pc) begin
          pc_d        = branch_target;
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_INIT;
          taken_inc   = 1'b1;
        end else if (halt_req) begin
          state_d = ST_HALTED;
        end else if (!stall) begin
          pc_d = pc + PC_W'(1);
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          pc_d        = pc + PC_W'(1);
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
          if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  sat_counter #(
    .WIDTH(TAKEN_W)
  ) u_taken (
    .clk  (clk),
    .rst  (rst),
    .inc  (taken_inc),
    .value(taken_count)
  );

endmodule

// File: tb/tb_pc_control.sv
// Randomized and directed checking of pc_control against a cycle-level
// behavioural model; saturation is exercised on a narrow sat_counter.
module tb_pc_control;
  import pc_control_pkg::*;

  localparam int          PC_W         = 16;
  localparam logic [15:0] RESET_PC     = 16'h0000;
  localparam int          FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel_pc = 1'b0;
  logic [15:0] branch_target = '0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic [15:0] pc;
  logic        flush;
  logic        halted;
  logic [15:0] taken_count;

  logic       small_rst = 1'b1;
  logic       small_inc = 1'b0;
  logic [3:0] small_value;

  int errors = 0;
  int checks = 0;

  // Model: remaining squash slots (0 = running), halt flag, pc, branch count.
  int m_pc = 0;
  int m_left = 0;
  int m_halted = 0;
  int m_count = 0;

  always #5 clk = ~clk;

  pc_control #(
    .PC_W        (PC_W),
    .RESET_PC    (RESET_PC),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_pc       (sel_pc),
    .branch_target(branch_target),
    .stall        (stall),
    .halt_req     (halt_req),
    .pc           (pc),
    .flush        (flush),
    .halted       (halted),
    .taken_count  (taken_count)
  );

  sat_counter #(
    .WIDTH(4)
  ) small_cnt (
    .clk  (clk),
    .rst  (small_rst),
    .inc  (small_inc),
    .value(small_value)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [15:0] t,
                               input logic st, input logic h);
    rst           = r;
    sel_pc        = s;
    branch_target = t;
    stall         = st;
    halt_req      = h;
    @(posedge clk);
    if (r) begin
      m_pc = int'(RESET_PC); m_left = 0; m_halted = 0; m_count = 0;
    end else if (m_halted != 0) begin
      m_pc = m_pc;
    end else if (m_left > 0) begin
      if (!st) begin
        m_pc   = (m_pc + 1) % 65536;
        m_left = m_left - 1;
      end
    end else if (s) begin
      m_pc    = int'(t);
      m_left  = FLUSH_CYCLES;
      m_count = (m_count < 65535) ? m_count + 1 : 65535;
    end else if (h) begin
      m_halted = 1;
    end else if (!st) begin
      m_pc = (m_pc + 1) % 65536;
    end
    #1;
    checkOutput("pc", 32'(pc), 32'(m_pc));
    checkOutput("flush", 32'(flush), (m_left > 0) ? 32'd1 : 32'd0);
    checkOutput("halted", 32'(halted), 32'(m_halted));
    checkOutput("taken_count", 32'(taken_count), 32'(m_count));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    int flush_seen;

    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    runCycles(5);
    checkOutput("linear_pc5", 32'(pc), 32'd5);

    runCycles(11);
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);
    checkOutput("branch_pc", 32'(pc), 32'h0200);
    applyStimulus(1'b0, 1'b1, 16'h0ABC, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("after_flush_pc", 32'(pc), 32'h0202);
    checkOutput("after_flush_flag", 32'(flush), 32'd0);
    runCycles(2);

    // Branch and halt together: the branch wins, then a clean halt freezes everything.
    applyStimulus(1'b0, 1'b1, 16'h0300, 1'b0, 1'b1);
    checkOutput("branch_over_halt", 32'(halted), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("halt_taken", 32'(halted), 32'd1);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
    checkOutput("reset_from_halt", 32'(halted), 32'd0);

    // Stalled squash window: 2 unstalled + 3 stalled flush cycles.
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
    flush_seen = 1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    flush_seen += 3;
    checkOutput("stall_hold_pc", 32'(pc), 32'h0040);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      if (flush) flush_seen++;
    end
    checkOutput("flush_total", 32'(flush_seen), 32'd5);

    applyStimulus(1'b0, 1'b1, 16'h0500, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("reset_mid_flush", 32'(flush), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Wrap of the program counter, inside and outside the squash window.
    applyStimulus(1'b0, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    runCycles(3);
    checkOutput("wrap_run", 32'(pc), 32'h0000);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("wrap_flush", 32'(pc), 32'h0000);
    runCycles(2);

    for (int i = 0; i < 500; i++) begin
      int roll;
      roll = int'($urandom_range(0, 99));
      applyStimulus(roll < 3, $urandom_range(0, 99) < 25, 16'($urandom),
                    $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 4);
    end

    // Saturation of the branch counter, shown on a 4-bit instance.
    small_rst = 1'b1;
    small_inc = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("small_reset", 32'(small_value), 32'd0);
    small_rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      small_inc = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("small_sat", 32'(small_value), (n < 15) ? 32'(n) : 32'd15);
    end
    small_inc = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("small_hold", 32'(small_value), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
